bcd_display_driver: RTL

Parametrised signed-binary to multi-digit 7-segment driver. It accepts a two's-complement value on a start strobe and converts it to BCD with an iterative double-dabble, one bit per clock. It then drives registered sign and digit segment patterns until the next conversion completes. It sits between the arithmetic datapath and the board displays and replaces fixed two-digit BCD decoding.

---
 rtl/bcd_display_pkg.sv | 20 ++
 rtl/seg7_encode.sv | 12 +
 rtl/bcd_display_driver.sv | 108 ++++++++++
 3 files changed

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: segment codes, state enum and BCD sizing shared by the display driver.
package bcd_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  // entry n holds the gfedcba pattern for digit n
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  typedef enum logic {IDLE, SHIFT} state_t;

  // ceil(width * log10(2)) using a fixed-point log10(2)
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: one BCD digit plus blank flag to active-high gfedcba segments.
module seg7_encode
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = (blank_i || digit_i > 4'd9) ? SEG_BLANK : SEG_TABLE[digit_i];

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: signed binary to multi-digit 7-segment driver via serial double-dabble.
// Define BCD_DISPLAY_LZB_EN to blank leading zero digits.
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      value_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [6:0]            signal_o,
  output logic [7*DIGITS-1:0]   digits_o
);

  localparam int NB = bcd_digits(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t                state_q;
  logic [4*NB-1:0]       acc_q, acc_adj, acc_d;
  logic [WIDTH-1:0]      mag_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q, done_q, ovf_q, ovf_d;
  logic [6:0]            sig_q;
  logic [7*DIGITS-1:0]   dig_q, dig_d;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NB; i++)
      acc_adj[4*i+:4] = acc_q[4*i+:4] >= 4'd5 ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
    acc_d = {acc_adj[4*NB-2:0], mag_q[WIDTH-1]};
    ovf_d = 1'b0;
    for (int i = DIGITS; i < NB; i++)
      ovf_d = ovf_d | (|acc_d[4*i+:4]);
  end

  // acc_d is the finished BCD value on the last shift cycle, so it is encoded directly
`ifdef BCD_DISPLAY_LZB_EN
  logic [DIGITS:0] lz;
  assign lz[DIGITS] = 1'b1;
`endif

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [3:0] dv;
    logic       bl;
    logic [6:0] seg;
    if (d < NB) begin : g_in
      assign dv = acc_d[4*d+:4];
    end else begin : g_out
      assign dv = 4'd0;
    end
`ifdef BCD_DISPLAY_LZB_EN
    assign lz[d] = lz[d+1] && dv == 4'd0;
    assign bl = (d != 0) && lz[d];
`else
    assign bl = 1'b0;
`endif
    seg7_encode u_seg (.digit_i(dv), .blank_i(bl), .seg_o(seg));
    assign dig_d[7*d+:7] = ovf_d ? SEG_MINUS : seg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sig_q   <= SEG_BLANK;
      dig_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i) begin
          neg_q   <= value_i[WIDTH-1];
          mag_q   <= value_i[WIDTH-1] ? -value_i : value_i;
          acc_q   <= '0;
          cnt_q   <= CW'(WIDTH);
          state_q <= SHIFT;
        end
      end else begin
        acc_q <= acc_d;
        mag_q <= mag_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          dig_q   <= dig_d;
          sig_q   <= neg_q ? SEG_MINUS : SEG_BLANK;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      end
    end
  end

  assign busy_o     = state_q == SHIFT;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign signal_o   = sig_q;
  assign digits_o   = dig_q;

endmodule
